// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
// Circular FIFO of free physical register tags. Hands up to two fresh
// destination tags per cycle to rename and takes back up to two retired
// tags per cycle. Allocation is all-or-nothing.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   alloc_num  [1:0]  in     tags requested (0..2; 3 is illegal)
//   alloc_gnt         out    request granted, head advances next edge
//   alloc_tag_0/1 [5:0] out  entries at head / head+1
//   stall_o           out    alloc_num > free_count
//   free_num   [1:0]  in     tags returned (0..2; 3 is illegal)
//   free_tag_0/1 [5:0] in    returned tags (tag 0 is ignored)
//   free_count [6:0]  out    registered number of free tags
//   err_o             out    sticky error (overflow, illegal encoding,
//                            double free when checking is enabled)
//
// Optional build macro FREE_LIST_CHECK_EN: keeps an in_list bitmap and
// rejects frees of tags already present in the list.
module phys_reg_free_list #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] alloc_num,
   output logic       alloc_gnt,
   output logic [5:0] alloc_tag_0,
   output logic [5:0] alloc_tag_1,
   output logic       stall_o,
   input  logic [1:0] free_num,
   input  logic [5:0] free_tag_0,
   input  logic [5:0] free_tag_1,
   output logic [6:0] free_count,
   output logic       err_o
);

   logic [5:0] entry_q [NUM_PREGS];
   logic [5:0] entry_d [NUM_PREGS];
   logic [5:0] head_q, head_d, tail_q, tail_d;
   logic [6:0] count_q, count_d;
   logic       err_q, err_d;
`ifdef FREE_LIST_CHECK_EN
   logic [NUM_PREGS-1:0] in_list_q, in_list_d;
`endif

   logic [1:0] n_alloc, n_free;
   logic [6:0] post, room;
   logic       cand0, cand1, dup0, dup1, acc0, acc1, ovf;

   always_comb begin
      entry_d  = entry_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      err_d    = err_q;
`ifdef FREE_LIST_CHECK_EN
      in_list_d = in_list_q;
`endif
      // Tag width equals log2(NUM_PREGS), so 6-bit pointer arithmetic
      // wraps modulo NUM_PREGS on its own (including head+1).
      alloc_tag_0 = entry_q[head_q];
      alloc_tag_1 = entry_q[head_q + 6'd1];
      stall_o     = {5'b0, alloc_num} > count_q;
      // Only the registered count qualifies a grant: same-cycle frees
      // never satisfy a same-cycle request.
      alloc_gnt   = rst_n && (alloc_num == 2'd1 || alloc_num == 2'd2) &&
                    ({5'b0, alloc_num} <= count_q);
      n_alloc     = alloc_gnt ? alloc_num : 2'd0;
      post        = count_q - {5'b0, n_alloc};

      cand0 = (free_num == 2'd1 || free_num == 2'd2) && (free_tag_0 != 6'd0);
      cand1 = (free_num == 2'd2) && (free_tag_1 != 6'd0);
      dup0  = 1'b0;
      dup1  = 1'b0;
`ifdef FREE_LIST_CHECK_EN
      // Checked against the registered bitmap; a tag being allocated this
      // cycle is still "in list" and so freeing it is a double free.
      dup0 = cand0 && in_list_q[free_tag_0];
      dup1 = cand1 && (in_list_q[free_tag_1] || (cand0 && free_tag_0 == free_tag_1));
`endif
      // Overflow drops free_tag_1 before free_tag_0.
      room = 7'(NUM_PREGS - 1) - post;
      acc0 = cand0 && !dup0 && (room != 7'd0);
      acc1 = cand1 && !dup1 && (room >= (acc0 ? 7'd2 : 7'd1));
      ovf  = (cand0 && !dup0 && !acc0) || (cand1 && !dup1 && !acc1);

      // Accepted tags are compacted: tag 1 lands at tail if tag 0 was dropped.
      if (acc0) entry_d[tail_q] = free_tag_0;
      if (acc1) entry_d[acc0 ? tail_q + 6'd1 : tail_q] = free_tag_1;
      n_free = {1'b0, acc0} + {1'b0, acc1};

      head_d  = head_q + {4'b0, n_alloc};
      tail_d  = tail_q + {4'b0, n_free};
      count_d = post + {5'b0, n_free};
      err_d   = err_q | (alloc_num == 2'd3) | (free_num == 2'd3) | ovf | dup0 | dup1;

`ifdef FREE_LIST_CHECK_EN
      if (n_alloc != 2'd0) in_list_d[alloc_tag_0] = 1'b0;
      if (n_alloc == 2'd2) in_list_d[alloc_tag_1] = 1'b0;
      if (acc0) in_list_d[free_tag_0] = 1'b1;
      if (acc1) in_list_d[free_tag_1] = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PREGS; i++)
            entry_q[i] <= (i < NUM_PREGS - NUM_AREGS) ? 6'(NUM_AREGS + i) : 6'd0;
         head_q  <= 6'd0;
         tail_q  <= 6'(NUM_PREGS - NUM_AREGS);
         count_q <= 7'(NUM_PREGS - NUM_AREGS);
         err_q   <= 1'b0;
`ifdef FREE_LIST_CHECK_EN
         for (int i = 0; i < NUM_PREGS; i++)
            in_list_q[i] <= (i >= NUM_AREGS);
`endif
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
`ifdef FREE_LIST_CHECK_EN
         in_list_q <= in_list_d;
`endif
      end
   end

   assign free_count = count_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] alloc_num = 2'd0;
   logic       alloc_gnt;
   logic [5:0] alloc_tag_0, alloc_tag_1;
   logic       stall_o;
   logic [1:0] free_num = 2'd0;
   logic [5:0] free_tag_0 = 6'd0, free_tag_1 = 6'd0;
   logic [6:0] free_count;
   logic       err_o;

   phys_reg_free_list dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_num(alloc_num), .alloc_gnt(alloc_gnt),
      .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
      .stall_o(stall_o),
      .free_num(free_num), .free_tag_0(free_tag_0), .free_tag_1(free_tag_1),
      .free_count(free_count), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit chk_state;
      bit gnt, stall, c0, c1, err;
      int t0, t1, cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   // Reference model: free list as a plain FIFO of tag numbers.
   int mq[$];
   bit merr;
   int outq[$];   // tags handed out, used to generate realistic frees

   function automatic bit in_q(input int t, input int q[$]);
      foreach (q[i]) if (q[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle; record expectation from the pre-edge model, then
   // advance the model by the specification's rules.
   task automatic step(input int an, input int fn, input int t0, input int t1, input bit rst);
      exp_t e;
      int   pre[$];
      int   seen[$];
      int   cnt;
      @(negedge clk);
      rst_n = !rst; alloc_num = 2'(an); free_num = 2'(fn);
      free_tag_0 = 6'(t0); free_tag_1 = 6'(t1);
      cnt = mq.size();
      e.chk_state = !rst;
      e.gnt   = !rst && (an == 1 || an == 2) && an <= cnt;
      e.stall = an > cnt;
      e.c0    = cnt >= 1;
      e.c1    = cnt >= 2;
      e.t0    = (cnt >= 1) ? mq[0] : 0;
      e.t1    = (cnt >= 2) ? mq[1] : 0;
      e.cnt   = cnt;
      e.err   = merr;
      exp_q.push_back(e);
      if (rst) begin
         mq = {};
         for (int i = 32; i < 64; i++) mq.push_back(i);
         merr = 0;
         outq = {};
      end else begin
         pre = mq;
         if (an == 3) merr = 1;
         if (e.gnt) for (int k = 0; k < an; k++) outq.push_back(mq.pop_front());
         if (fn == 3) merr = 1;
         else for (int k = 0; k < fn; k++) begin
            int tg;
            tg = (k == 0) ? t0 : t1;
            if (tg == 0) continue;
`ifdef FREE_LIST_CHECK_EN
            if (in_q(tg, pre) || in_q(tg, seen)) begin merr = 1; continue; end
            seen.push_back(tg);
`endif
            if (mq.size() >= 63) begin merr = 1; continue; end
            mq.push_back(tg);
         end
      end
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("alloc_gnt", int'(alloc_gnt), int'(e.gnt));
            if (e.chk_state) begin
               chk("stall_o", int'(stall_o), int'(e.stall));
               chk("free_count", int'(free_count), e.cnt);
               chk("err_o", int'(err_o), int'(e.err));
               if (e.c0) chk("alloc_tag_0", int'(alloc_tag_0), e.t0);
               if (e.c1) chk("alloc_tag_1", int'(alloc_tag_1), e.t1);
            end
         end
      end
   end

   function automatic int pick_tag();
      if (outq.size() != 0 && $urandom_range(0, 9) < 8)
         return outq.pop_front();
      return int'($urandom_range(0, 63));
   endfunction

   initial begin
      int an, fn, a, b, wait_cyc;
      // Reset held two cycles with an active request: grant must stay low.
      step(2, 0, 0, 0, 1);
      step(2, 0, 0, 0, 1);
      // Drain: tags 32..63 in order, then a single request stalls.
      for (int i = 0; i < 16; i++) step(2, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      // Empty with same-cycle free: no grant, tags visible next cycle.
      step(1, 2, 5, 9, 0);
      step(0, 0, 0, 0, 0);
      step(2, 0, 0, 0, 0);
      // Fill with 1..63 across the pointer wrap, then zero tag and overflow.
      for (int i = 1; i < 63; i += 2) step(0, 2, i, i + 1, 0);
      step(0, 1, 63, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 7, 0, 0);
      for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 0);
      // Double free of a tag still in the list after reset.
      step(0, 0, 0, 0, 1);
      step(0, 1, 40, 0, 0);
      step(0, 0, 0, 0, 0);
      // Reset mid-burst.
      step(2, 2, 3, 4, 1);
      step(0, 0, 0, 0, 0);
      // Illegal encodings.
      step(3, 0, 0, 0, 0);
      step(0, 3, 11, 12, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         an = ($urandom_range(0, 99) < 2) ? 3 : int'($urandom_range(0, 2));
         fn = ($urandom_range(0, 99) < 2) ? 3 : int'($urandom_range(0, 2));
         a = pick_tag();
         b = pick_tag();
         step(an, fn, a, b, $urandom_range(0, 199) == 0);
      end
      step(0, 0, 0, 0, 0);
      wait_cyc = 0;
      while (exp_q.size() != 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      #5;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular FIFO of free physical register tags for the out-of-order core. Sits beside the reorder buffer: it hands up to two fresh destination tags per cycle to rename/dispatch (the source of `curr_dest_reg_1/2`) and takes back up to two old destination tags per cycle from ROB retirement (`num_retired`, `old_d_reg` of `rob_o_1/2`). Allocation is all-or-nothing, and the block stalls rename when it cannot satisfy a request.

## Interface
- `NUM_PREGS`, 64: physical registers. Tag width is fixed at 6 bits.
- `NUM_AREGS`, 32: architectural registers. Pregs 0..NUM_AREGS-1 are mapped at reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `alloc_num` input 2: tags requested this cycle (0, 1 or 2).
- `alloc_gnt` output 1: request granted; head advances at the next edge.
- `alloc_tag_0` output 6: first tag, the entry at head.
- `alloc_tag_1` output 6: second tag, the entry at head+1.
- `stall_o` output 1: `alloc_num` > `free_count`.
- `free_num` input 2: tags returned by retirement (0, 1 or 2), driven from `num_retired`.
- `free_tag_0` input 6: first returned tag.
- `free_tag_1` input 6: second returned tag.
- `free_count` output 7: registered count of free tags.
- `err_o` output 1: sticky error flag, cleared only by reset.

## Operation
- **Storage.** NUM_PREGS-entry array with 6-bit `head`/`tail` pointers that wrap modulo NUM_PREGS. Capacity is NUM_PREGS-1, because tag 0 never enters the list.
- **Reset.** `entry[i]` = NUM_AREGS+i for i < NUM_PREGS-NUM_AREGS. `head`=0, `tail`=32, `free_count`=32, `err_o`=0.
- **Grant.** `alloc_gnt` = (`alloc_num`∈{1,2}) && (`alloc_num` ≤ `free_count`).
  - The check uses the registered count only. Same-cycle frees never satisfy same-cycle allocation.
  - On grant, `head` += `alloc_num`.
  - `alloc_num`=1 consumes only `alloc_tag_0`.
- **Free.** Valid returned tags are written at `tail`, `tail+1` in order: `free_tag_0` first, then `free_tag_1`.
  - Tag 0 is dropped silently and not counted. Any other return is compacted, e.g. if `free_tag_0`=0, `free_tag_1` goes to `tail`.
- **Count.** `free_count` next = `free_count` − granted allocs + accepted frees.
- **Overflow.** If the post-alloc count plus frees would exceed NUM_PREGS-1, the excess frees are dropped (`free_tag_1` before `free_tag_0`) and `err_o` is set.
- **Illegal encodings.** `alloc_num`=3 is treated as 0 and sets `err_o`. `free_num`=3 is treated as 0 and sets `err_o`.
- **Simultaneous alloc and free.** Pointers and array write are independent: the read is at head, the write at tail. When the list is empty, a freed tag appears at `alloc_tag_0` the next cycle.

## Timing
- `alloc_tag_0/1`, `alloc_gnt` and `stall_o` are combinational from registered state and `alloc_num`. Zero-cycle grant latency.
- All state updates on the rising edge of `clk`.
- Free-to-allocatable latency is 1 cycle minimum. There is no bypass.
- `rst_n` low at an edge overrides all activity that cycle, including mid-burst alloc/free. The next cycle shows reset values.
  - While `rst_n` is low, `alloc_gnt` is forced to 0.
  - `alloc_tag_0/1` read 32/33 the cycle after reset.
- **Pointer wrap.** 63+1→0 and 63+2→1. The array read at head+1 also wraps.
- **Empty.** `free_count`=0 → any request stalls. `alloc_tag_*` are don't-care.
- **Count of 1.** Request of 2 stalls (no partial grant); request of 1 is granted.

## Configuration
- `FREE_LIST_CHECK_EN` defined: a NUM_PREGS-bit `in_list` bitmap is maintained.
  - Set on accepted free; cleared on allocation; reset value has bits 32..63 set.
  - A free of a tag already in the list is dropped, not counted, and sets `err_o`.
  - Two equal tags in one cycle: the second is a double free.
- `FREE_LIST_CHECK_EN` undefined: no bitmap and no duplicate detection. `err_o` reflects only overflow and illegal encodings.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 cycles, release → `free_count`=32, `alloc_tag_0`=32, `alloc_tag_1`=33, `err_o`=0, `alloc_gnt`=0 during reset.
- **Drain.** `alloc_num`=2 for 16 cycles → tags 32..63 in order, `free_count`=0. Then `alloc_num`=1 → `stall_o`=1, `alloc_gnt`=0.
- **Empty with same-cycle free.** At `free_count`=0, `alloc_num`=1 with `free_num`=2, tags 5 and 9 → no grant that cycle. Next cycle `alloc_tag_0`=5, `alloc_tag_1`=9, `free_count`=2.
- **Wrap and zero tag.** Run the list empty, then free 63 distinct tags 1..63, then issue `free_num`=1 with tag 0 → tag 0 ignored, `err_o`=0. Issue one more free of tag 7 → dropped, `err_o`=1. Allocate 64 times across the wrap → tags return 1..63 in order.
- **Double free** (`FREE_LIST_CHECK_EN` on). Free tag 40 while it is still in the list → `free_count` unchanged, `err_o`=1. With the macro off, same stimulus → `free_count`+1, `err_o`=0.
- **Reset mid-operation.** Assert `rst_n`=0 while `alloc_num`=2 and `free_num`=2 → next cycle exact reset state, `free_count`=32.
